// File: rtl/dual_chan_merge.sv
// Two-channel merge: per-channel FIFOs drained by a round-robin arbiter into
// one registered output word tagged with its source channel.

module dual_chan_merge_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_valid,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic                          ready,
  output logic                          nonempty,
  output logic [DATA_W-1:0]             head,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     lvl;
  logic              push;

  assign ready    = (lvl != LW'(FIFO_DEPTH));
  assign nonempty = (lvl != '0);
  assign push     = push_valid && ready;
  assign head     = mem[rd_ptr];
  assign level    = lvl;

  // Storage carries no reset: emptiness is tracked purely by the pointers/level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   lvl <= lvl + LW'(1);
        2'b01:   lvl <= lvl - LW'(1);
        default: lvl <= lvl;
      endcase
    end
  end

endmodule

module dual_chan_merge #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sig_a_valid,
  input  logic [DATA_W-1:0]             sig_a_data_in,
  output logic                          sig_a_ready,
  input  logic                          sig_b_valid,
  input  logic [DATA_W-1:0]             sig_b_data_in,
  output logic                          sig_b_ready,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_src,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   sig_a_level,
  output logic [$clog2(FIFO_DEPTH):0]   sig_b_level
);

  logic              ne_a;
  logic              ne_b;
  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;
  logic              load;
  logic              sel_b;
  logic              pop_a;
  logic              pop_b;

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic              src_p0;
  logic              last_src;

  dual_chan_merge_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (sig_a_valid),
    .push_data  (sig_a_data_in),
    .pop        (pop_a),
    .ready      (sig_a_ready),
    .nonempty   (ne_a),
    .head       (head_a),
    .level      (sig_a_level)
  );

  dual_chan_merge_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (sig_b_valid),
    .push_data  (sig_b_data_in),
    .pop        (pop_b),
    .ready      (sig_b_ready),
    .nonempty   (ne_b),
    .head       (head_b),
    .level      (sig_b_level)
  );

  // B wins when it is the only source, or on a tie when A was served last.
  assign load  = (!vld_p0 || out_ready) && (ne_a || ne_b);
  assign sel_b = ne_b && (!ne_a || !last_src);
  assign pop_a = load && !sel_b;
  assign pop_b = load && sel_b;

  // Stage p0: registered merged output word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      data_p0  <= '0;
      src_p0   <= 1'b0;
      last_src <= 1'b1;
    end else if (load) begin
      vld_p0   <= 1'b1;
      data_p0  <= sel_b ? head_b : head_a;
      src_p0   <= sel_b;
      last_src <= sel_b;
    end else if (out_ready) begin
      vld_p0   <= 1'b0;
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign out_src   = src_p0;

endmodule
